// File: rtl/gpu_mem_pkg.sv
// Shared types for the global-memory responder and its arbiter.
// No logic here: latency and backpressure are defined by the modules that import it.
package gpu_mem_pkg;

  localparam int LAT_BITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    DONE
  } chan_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr; combinational, zero latency.
// No backpressure of its own; a losing requester simply stays asserted until granted.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [PTR_BITS-1:0] grant_idx,
  output logic                any_grant,
  output logic [PTR_BITS-1:0] next_ptr
);

  logic [PTR_BITS:0]   sum;
  logic [PTR_BITS-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Modular add so non-power-of-two channel counts wrap correctly
      sum = {1'b0, ptr} + (PTR_BITS + 1)'(i);
      if (sum >= (PTR_BITS + 1)'(NUM_REQ)) sum = sum - (PTR_BITS + 1)'(NUM_REQ);
      idx = sum[PTR_BITS-1:0];
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  assign next_ptr = (grant_idx == PTR_BITS'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

endmodule

// File: rtl/gpu_mem_responder.sv
// Multi-channel memory responder: one shared array, round-robin grant; ready fires LAT cycles after grant-1.
// Backpressure: a channel holds its request in REQ until granted; valid must drop before a new request is taken.
module gpu_mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CHANNELS-1:0]              mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]              mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]              mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]              mem_write_ready
);

  localparam int CH_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int DEPTH   = 2 ** ADDR_BITS;
  localparam logic [LAT_BITS-1:0] RD_LOAD = LAT_BITS'(READ_LATENCY - 1);
  localparam logic [LAT_BITS-1:0] WR_LOAD = LAT_BITS'(WRITE_LATENCY - 1);

  logic [DATA_BITS-1:0]    mem [DEPTH];
  logic [NUM_CHANNELS-1:0] req;
  logic [NUM_CHANNELS-1:0] grant;
  logic                    gnt_any;
  logic [CH_BITS-1:0]      gnt_idx;
  logic [CH_BITS-1:0]      rr_ptr;
  logic [CH_BITS-1:0]      next_ptr;
  op_t                     ch_op    [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    ch_addr  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    ch_wdata [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    gnt_addr;
  logic [DATA_BITS-1:0]    array_rdata;

  rr_arbiter #(
    .NUM_REQ (NUM_CHANNELS),
    .PTR_BITS(CH_BITS)
  ) u_arb (
    .req      (req),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_idx(gnt_idx),
    .any_grant(gnt_any),
    .next_ptr (next_ptr)
  );

  assign gnt_addr    = ch_addr[gnt_idx];
  assign array_rdata = mem[gnt_addr];

  // Storage is deliberately outside reset so contents survive it
  always_ff @(posedge clk) begin
    if (!reset && gnt_any && ch_op[gnt_idx] == OP_WRITE) mem[gnt_addr] <= ch_wdata[gnt_idx];
  end

  always_ff @(posedge clk) begin
    if (reset)        rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= next_ptr;
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    chan_state_t          state_q;
    op_t                  op_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [DATA_BITS-1:0] rdata_q;
    logic [LAT_BITS-1:0]  cnt_q;
    logic                 rd_rdy_q;
    logic                 wr_rdy_q;
    logic [LAT_BITS-1:0]  load_val;
    logic                 op_valid;

    assign load_val = (op_q == OP_READ) ? RD_LOAD : WR_LOAD;
    assign op_valid = (op_q == OP_READ) ? mem_read_valid[g] : mem_write_valid[g];

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= IDLE;
        op_q     <= OP_READ;
        addr_q   <= '0;
        wdata_q  <= '0;
        rdata_q  <= '0;
        cnt_q    <= '0;
        rd_rdy_q <= 1'b0;
        wr_rdy_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // Read wins when both are offered; the write is picked up on a later request
            if (mem_read_valid[g]) begin
              op_q    <= OP_READ;
              addr_q  <= mem_read_address[g];
              state_q <= REQ;
            end else if (mem_write_valid[g]) begin
              op_q    <= OP_WRITE;
              addr_q  <= mem_write_address[g];
              wdata_q <= mem_write_data[g];
              state_q <= REQ;
            end
          end
          REQ: begin
            if (grant[g]) begin
              if (op_q == OP_READ) rdata_q <= array_rdata;
              cnt_q <= load_val;
              if (load_val == '0) begin
                state_q  <= RESP;
                rd_rdy_q <= (op_q == OP_READ);
                wr_rdy_q <= (op_q == OP_WRITE);
              end else begin
                state_q <= WAIT;
              end
            end
          end
          WAIT: begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == LAT_BITS'(1)) begin
              state_q  <= RESP;
              rd_rdy_q <= (op_q == OP_READ);
              wr_rdy_q <= (op_q == OP_WRITE);
            end
          end
          RESP: begin
            rd_rdy_q <= 1'b0;
            wr_rdy_q <= 1'b0;
            state_q  <= DONE;
          end
          DONE: begin
            if (!op_valid) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign req[g]             = (state_q == REQ);
    assign ch_op[g]           = op_q;
    assign ch_addr[g]         = addr_q;
    assign ch_wdata[g]        = wdata_q;
    assign mem_read_ready[g]  = rd_rdy_q;
    assign mem_write_ready[g] = wr_rdy_q;
    assign mem_read_data[g]   = rdata_q;
  end

endmodule

// File: tb/tb_gpu_mem_responder.sv
// Directed bench for gpu_mem_responder with default parameters (4 ch, 8b addr/data, RL=2, WL=1).
module tb_gpu_mem_responder;

  localparam int NC = 4;
  localparam int AB = 8;
  localparam int DB = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NC-1:0]         mem_read_valid;
  logic [NC-1:0][AB-1:0] mem_read_address;
  logic [NC-1:0]         mem_read_ready;
  logic [NC-1:0][DB-1:0] mem_read_data;
  logic [NC-1:0]         mem_write_valid;
  logic [NC-1:0][AB-1:0] mem_write_address;
  logic [NC-1:0][DB-1:0] mem_write_data;
  logic [NC-1:0]         mem_write_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gpu_mem_responder #(
    .NUM_CHANNELS (NC),
    .ADDR_BITS    (AB),
    .DATA_BITS    (DB),
    .READ_LATENCY (2),
    .WRITE_LATENCY(1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .mem_write_valid  (mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data   (mem_write_data),
    .mem_write_ready  (mem_write_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int ch, input logic [AB-1:0] a, input logic [DB-1:0] d);
    int n;
    mem_write_valid[ch]   = 1'b1;
    mem_write_address[ch] = a;
    mem_write_data[ch]    = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (mem_write_ready[ch] !== 1'b1 && n < 20);
    checks++;
    if (mem_write_ready[ch] !== 1'b1) begin
      errors++;
      $display("FAIL wr_timeout ch%0d: ready=%b want 1 within 20 cycles", ch, mem_write_ready[ch]);
    end
    mem_write_valid[ch] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_read(input int ch, input logic [AB-1:0] a, output logic [DB-1:0] d);
    int n;
    mem_read_valid[ch]   = 1'b1;
    mem_read_address[ch] = a;
    n = 0;
    do begin
      tick();
      n++;
    end while (mem_read_ready[ch] !== 1'b1 && n < 20);
    checks++;
    if (mem_read_ready[ch] !== 1'b1) begin
      errors++;
      $display("FAIL rd_timeout ch%0d: ready=%b want 1 within 20 cycles", ch, mem_read_ready[ch]);
    end
    d = mem_read_data[ch];
    mem_read_valid[ch] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    reset             = 1'b1;
    mem_read_valid    = '0;
    mem_read_address  = '0;
    mem_write_valid   = '0;
    mem_write_address = '0;
    mem_write_data    = '0;
    repeat (3) tick();
    checks++;
    if (mem_read_ready !== 4'b0) begin
      errors++; $display("FAIL rst_rd_ready: got %b want 0000", mem_read_ready);
    end
    checks++;
    if (mem_write_ready !== 4'b0) begin
      errors++; $display("FAIL rst_wr_ready: got %b want 0000", mem_write_ready);
    end
    checks++;
    if (mem_read_data !== 32'h0) begin
      errors++; $display("FAIL rst_rd_data: got %h want 00000000", mem_read_data);
    end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_write_read;
    mem_write_valid[0] = 1'b1; mem_write_address[0] = 8'h12; mem_write_data[0] = 8'hA5;
    tick();
    checks++;
    if (mem_write_ready[0] !== 1'b0) begin
      errors++; $display("FAIL wr_at_capture: got %b want 0", mem_write_ready[0]);
    end
    tick();
    checks++;
    if (mem_write_ready[0] !== 1'b1) begin
      errors++; $display("FAIL wr_ready_e1: got %b want 1", mem_write_ready[0]);
    end
    mem_write_valid[0] = 1'b0;
    tick();
    checks++;
    if (mem_write_ready[0] !== 1'b0) begin
      errors++; $display("FAIL wr_ready_pulse: got %b want 0", mem_write_ready[0]);
    end
    repeat (2) tick();
    mem_read_valid[0] = 1'b1; mem_read_address[0] = 8'h12;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (mem_read_ready[0] !== 1'b0) begin
        errors++; $display("FAIL rd_early k=%0d: got %b want 0", k, mem_read_ready[0]);
      end
    end
    tick();
    checks++;
    if (mem_read_ready[0] !== 1'b1) begin
      errors++; $display("FAIL rd_ready_e2: got %b want 1", mem_read_ready[0]);
    end
    checks++;
    if (mem_read_data[0] !== 8'hA5) begin
      errors++; $display("FAIL rd_data: got %h want a5", mem_read_data[0]);
    end
    mem_read_valid[0] = 1'b0;
    tick();
    checks++;
    if (mem_read_ready[0] !== 1'b0 || mem_read_data[0] !== 8'hA5) begin
      errors++; $display("FAIL rd_hold: got ready=%b data=%h want 0/a5", mem_read_ready[0], mem_read_data[0]);
    end
    repeat (2) tick();
  endtask

  task automatic test_contention;
    for (int c = 0; c < NC; c++) do_write(c, AB'(c), DB'(8'h10 + c));
    for (int c = 0; c < NC; c++) begin
      mem_read_valid[c] = 1'b1; mem_read_address[c] = AB'(c);
    end
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        checks++;
        if (mem_read_ready[c] !== (k == c + 2)) begin
          errors++; $display("FAIL cont_ready ch%0d k=%0d: got %b want %b", c, k, mem_read_ready[c], (k == c + 2));
        end
        if (k == c + 2) begin
          checks++;
          if (mem_read_data[c] !== DB'(8'h10 + c)) begin
            errors++; $display("FAIL cont_data ch%0d: got %h want %h", c, mem_read_data[c], DB'(8'h10 + c));
          end
          mem_read_valid[c] = 1'b0;
        end
      end
    end
    repeat (2) tick();
    // Pointer should be back at 0: ch0 must beat ch3
    mem_read_valid[0] = 1'b1; mem_read_address[0] = 8'h00;
    mem_read_valid[3] = 1'b1; mem_read_address[3] = 8'h03;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (mem_read_ready[0] !== (k == 2) || mem_read_ready[3] !== (k == 3)) begin
        errors++; $display("FAIL ptr0_order k=%0d: got ch0=%b ch3=%b want %b/%b", k, mem_read_ready[0], mem_read_ready[3], (k == 2), (k == 3));
      end
      if (k == 2) mem_read_valid[0] = 1'b0;
      if (k == 3) begin
        checks++;
        if (mem_read_data[3] !== 8'h13) begin
          errors++; $display("FAIL ptr0_data ch3: got %h want 13", mem_read_data[3]);
        end
        mem_read_valid[3] = 1'b0;
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_raw_order;
    logic [DB-1:0] d;
    do_write(0, 8'h40, 8'h55);
    mem_write_valid[1] = 1'b1; mem_write_address[1] = 8'h40; mem_write_data[1] = 8'h77;
    mem_read_valid[2]  = 1'b1; mem_read_address[2]  = 8'h40;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (mem_write_ready[1] !== (k == 1) || mem_read_ready[2] !== (k == 3)) begin
        errors++; $display("FAIL raw_p1 k=%0d: got wr1=%b rd2=%b want %b/%b", k, mem_write_ready[1], mem_read_ready[2], (k == 1), (k == 3));
      end
      if (k == 1) mem_write_valid[1] = 1'b0;
      if (k == 3) begin
        checks++;
        if (mem_read_data[2] !== 8'h77) begin
          errors++; $display("FAIL raw_p1_data: got %h want 77", mem_read_data[2]);
        end
        mem_read_valid[2] = 1'b0;
      end
    end
    repeat (2) tick();
    do_write(1, 8'h41, 8'h00);
    mem_write_valid[1] = 1'b1; mem_write_address[1] = 8'h40; mem_write_data[1] = 8'h99;
    mem_read_valid[2]  = 1'b1; mem_read_address[2]  = 8'h40;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (mem_write_ready[1] !== (k == 2) || mem_read_ready[2] !== (k == 2)) begin
        errors++; $display("FAIL raw_p2 k=%0d: got wr1=%b rd2=%b want %b/%b", k, mem_write_ready[1], mem_read_ready[2], (k == 2), (k == 2));
      end
      if (k == 2) begin
        checks++;
        if (mem_read_data[2] !== 8'h77) begin
          errors++; $display("FAIL raw_p2_data: got %h want 77", mem_read_data[2]);
        end
        mem_write_valid[1] = 1'b0;
        mem_read_valid[2]  = 1'b0;
      end
    end
    repeat (2) tick();
    do_read(3, 8'h40, d);
    checks++;
    if (d !== 8'h99) begin
      errors++; $display("FAIL raw_p2_final: got %h want 99", d);
    end
  endtask

  task automatic test_no_double;
    int pulses;
    mem_read_valid[3] = 1'b1; mem_read_address[3] = 8'h01;
    repeat (3) tick();
    checks++;
    if (mem_read_ready[3] !== 1'b1 || mem_read_data[3] !== 8'h11) begin
      errors++; $display("FAIL nodbl_first: got ready=%b data=%h want 1/11", mem_read_ready[3], mem_read_data[3]);
    end
    pulses = 0;
    repeat (6) begin
      tick();
      if (mem_read_ready[3] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL nodbl_extra: got %0d extra pulses want 0", pulses);
    end
    mem_read_valid[3] = 1'b0;
    tick();
    mem_read_valid[3] = 1'b1; mem_read_address[3] = 8'h02;
    repeat (2) tick();
    checks++;
    if (mem_read_ready[3] !== 1'b0) begin
      errors++; $display("FAIL nodbl_early: got %b want 0", mem_read_ready[3]);
    end
    tick();
    checks++;
    if (mem_read_ready[3] !== 1'b1 || mem_read_data[3] !== 8'h12) begin
      errors++; $display("FAIL nodbl_rearm: got ready=%b data=%h want 1/12", mem_read_ready[3], mem_read_data[3]);
    end
    mem_read_valid[3] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back;
    do_write(0, 8'h20, 8'hC1);
    do_write(0, 8'h21, 8'hC2);
    mem_read_valid[0] = 1'b1; mem_read_address[0] = 8'h20;
    repeat (3) tick();
    checks++;
    if (mem_read_ready[0] !== 1'b1 || mem_read_data[0] !== 8'hC1) begin
      errors++; $display("FAIL b2b_first: got ready=%b data=%h want 1/c1", mem_read_ready[0], mem_read_data[0]);
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (mem_read_ready[0] !== (k == 5)) begin
        errors++; $display("FAIL b2b_ready k=%0d: got %b want %b", k, mem_read_ready[0], (k == 5));
      end
      if (k == 1) begin mem_read_valid[0] = 1'b0; mem_read_address[0] = 8'h21; end
      if (k == 2) mem_read_valid[0] = 1'b1;
      if (k == 5) begin
        checks++;
        if (mem_read_data[0] !== 8'hC2) begin
          errors++; $display("FAIL b2b_data: got %h want c2", mem_read_data[0]);
        end
        mem_read_valid[0] = 1'b0;
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_op;
    logic [DB-1:0] d;
    do_write(0, 8'h30, 8'h3C);
    mem_read_valid[0] = 1'b1; mem_read_address[0] = 8'h30;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (mem_read_ready !== 4'b0 || mem_write_ready !== 4'b0) begin
      errors++; $display("FAIL rstmid_ready: got rd=%b wr=%b want 0000/0000", mem_read_ready, mem_write_ready);
    end
    checks++;
    if (mem_read_data !== 32'h0) begin
      errors++; $display("FAIL rstmid_data: got %h want 00000000", mem_read_data);
    end
    reset = 1'b0;
    mem_read_valid[0] = 1'b0;
    tick();
    checks++;
    if (mem_read_ready[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_late: got %b want 0", mem_read_ready[0]);
    end
    tick();
    do_read(0, 8'h30, d);
    checks++;
    if (d !== 8'h3C) begin
      errors++; $display("FAIL rstmid_keep: got %h want 3c", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_raw_order();
    test_no_double();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpu_mem_responder.md
Name: gpu_mem_responder

Overview:
- Synthesizable multi-channel global-memory responder: the memory-side end of the per-channel valid/ready read and write protocol driven by the data/program cache controllers.
- Replaces the behavioural bench memory, so cache and core RTL can be simulated, or run on FPGA, with a real timing model.
- One single-ported storage array is shared by all channels through a round-robin arbiter.
- Responses follow a fixed, parameterised latency measured from grant.

Parameters:
- NUM_CHANNELS, 4, number of independent request channels.
- ADDR_BITS, 8, address width; storage depth is 2**ADDR_BITS words.
- DATA_BITS, 8, word width.
- READ_LATENCY, 2, read latency; legal range 1..15.
- WRITE_LATENCY, 1, write latency; legal range 1..15.

Ports:
- Clock and reset (already decided): reset, synchronous, active-high; clock clk.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mem_read_valid  in  [NUM_CHANNELS]  read request, held high by the initiator until it sees ready.
- mem_read_address  in  [ADDR_BITS] x NUM_CHANNELS  read address.
- mem_read_ready  out  [NUM_CHANNELS]  one-cycle read-done pulse.
- mem_read_data  out  [DATA_BITS] x NUM_CHANNELS  read data; valid while ready is high, held until the next read completes.
- mem_write_valid  in  [NUM_CHANNELS]  write request.
- mem_write_address  in  [ADDR_BITS] x NUM_CHANNELS  write address.
- mem_write_data  in  [DATA_BITS] x NUM_CHANNELS  write data.
- mem_write_ready  out  [NUM_CHANNELS]  one-cycle write-done pulse.

Behaviour:
- Reset:
  - All ready and data outputs 0.
  - Every channel FSM in IDLE.
  - Round-robin pointer = 0.
  - Storage contents are not reset and are preserved across reset.
- Per-channel FSM states: IDLE, REQ, WAIT, RESP, DONE.
- IDLE:
  - On an edge where read or write valid is sampled high (call it E0), latch op, address and write data, then go to REQ.
  - If read and write valid are both high, the read is taken and the write waits for a later request.
- REQ: request arbitration for the array. The arbiter picks one channel per cycle: the first REQ channel at or after the pointer. At that grant edge:
  - A read captures array[addr] into the channel's data register.
  - A write updates array[addr].
  - The pointer moves to granted+1, mod NUM_CHANNELS.
  - The latency counter loads LAT-1, where LAT is the op's latency.
  - If LAT-1 = 0, the channel goes straight to RESP; otherwise it goes to WAIT.
- WAIT: decrement the counter each cycle; on reaching 0, go to RESP. The matching ready register is set on the same edge the FSM enters RESP.
- RESP: ready is high for exactly one cycle; then ready clears and the FSM goes to DONE.
- DONE: return to IDLE on the first edge where the captured op's valid is sampled low. This guarantees no double response while the initiator's valid is still falling.
- Uncontended timing:
  - Ready rises at edge E0+LAT.
  - Earliest next capture on the channel is E0+LAT+3, which matches an initiator that drops valid on seeing ready and re-raises it one cycle later.
- Contention: with k channels entering REQ on the same edge, the m-th granted (m = 0..k-1, in round-robin order) sees ready m cycles later than uncontended.
- Ordering: array accesses are strictly serialized in grant order. A read granted after a write to the same address returns the new data.
- Request changes:
  - Valid deasserted while in REQ or WAIT is ignored; the request completes and pulses ready.
  - Address or data changes after capture are ignored.
- Address width: addresses cover the full 2**ADDR_BITS space with no wrap or out-of-range case.
- Reset mid-operation: in-flight requests are dropped with no ready pulse. A write that was already granted remains in storage.

Decomposition:
- Shared package gpu_mem_pkg holds:
  - the channel state enum (IDLE/REQ/WAIT/RESP/DONE);
  - op type (OP_READ/OP_WRITE);
  - LAT_BITS = 4.
- Sub-module rr_arbiter: NUM_CHANNELS request vector in, one-hot grant and pointer update out. It is reusable by the cache controllers.

Test Plan (default parameters):
- Write, then read (single channel):
  - Ch0 write addr 0x12 data 0xA5, valid captured at edge 10 -> write_ready[0] high in cycle after edge 11 only.
  - Ch0 read 0x12 captured at edge 15 -> read_ready[0] at edge 17, read_data[0] = 0xA5, held afterward.
- Contention: all 4 channels read addrs 0x00..0x03 (preloaded 0x10..0x13) captured at the same edge E with pointer 0 -> ready on ch0..ch3 at E+2, E+3, E+4, E+5 with matching data; pointer ends at 0.
- Read-after-write ordering: ch1 write 0x40 := 0x77 and ch2 read 0x40 captured at the same edge with pointer 1 -> ch2 returns 0x77; with pointer 2 it returns the old value.
- No double response: hold read_valid[3] high for 6 cycles after ready -> exactly one ready pulse; the FSM stays in DONE until valid drops, then accepts a new request.
- Back-to-back cache-line fill: ch0 issues 2 sequential reads (addr 0x20, 0x21) following the drop-one-cycle/re-raise pattern -> two ready pulses 5 edges apart, correct data each.
- Reset mid-operation: assert reset during ch0 WAIT -> no ready pulse; outputs 0 next cycle; a prior granted write to 0x30 still reads back after reset.
